// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: merges inst and data sram-like ports onto one downstream port, routing in-order responses by tag
module sram_like_arbiter #(
  parameter int DEPTH = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  logic [DEPTH-1:0] tag_q;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [SW-1:0] starve;
  logic full, force_inst, grant_data, grant_inst, push, pop, head;
  always_comb begin
    full = count == FULL_CNT;
    force_inst = inst_sram_req & (starve == SMAX);
    grant_data = !reset & !full & data_sram_req & !force_inst;
    grant_inst = !reset & !full & inst_sram_req & !grant_data;
    mem_req = grant_data | grant_inst;
    mem_wr = grant_data & data_sram_wr;
    mem_size = grant_data ? data_sram_size : inst_sram_size;
    mem_addr = grant_data ? data_sram_addr : inst_sram_addr;
    mem_wstrb = grant_data ? data_sram_wstrb : 4'b0;
    mem_wdata = grant_data ? data_sram_wdata : 32'b0;
    data_sram_addr_ok = grant_data & mem_addr_ok;
    inst_sram_addr_ok = grant_inst & mem_addr_ok;
    push = mem_req & mem_addr_ok;
    pop = !reset & mem_data_ok & (count != '0);
    head = tag_q[rd_ptr];
    inst_sram_data_ok = pop & !head;
    data_sram_data_ok = pop & head;
    inst_sram_rdata = mem_rdata;
    data_sram_rdata = mem_rdata;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      starve <= '0;
    end else begin
      if (push) begin
        tag_q[wr_ptr] <= grant_data;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (!inst_sram_req || (push && grant_inst)) starve <= '0;
      else if (push && grant_data && starve != SMAX) starve <= starve + 1'b1;
    end
  end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter: directed checks of grant priority, starvation guard, tag routing, full, reset and spurious responses
module tb_sram_like_arbiter;
  logic clk = 0, reset;
  logic inst_sram_req, inst_sram_addr_ok, inst_sram_data_ok;
  logic [1:0] inst_sram_size;
  logic [31:0] inst_sram_addr, inst_sram_rdata;
  logic data_sram_req, data_sram_wr, data_sram_addr_ok, data_sram_data_ok;
  logic [1:0] data_sram_size;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic [3:0] data_sram_wstrb;
  logic mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0] mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_wstrb;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  sram_like_arbiter dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_addr(data_sram_addr), .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string t, logic [31:0] o, logic [31:0] e);
    checks++;
    if (o !== e) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", t, o, e);
    end
  endtask
  initial begin
    reset = 1;
    inst_sram_req = 1; inst_sram_size = 2'd2; inst_sram_addr = 32'h0;
    data_sram_req = 1; data_sram_wr = 1; data_sram_size = 2'd2; data_sram_addr = 32'h1000;
    data_sram_wstrb = 4'hF; data_sram_wdata = 32'hFFFF_FFFF;
    mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h0;
    cyc(); cyc();
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_inst_addr_ok", inst_sram_addr_ok, 1'b0);
    chk("rst_data_addr_ok", data_sram_addr_ok, 1'b0);
    chk("rst_data_ok", {inst_sram_data_ok, data_sram_data_ok}, 2'b00);
    chk("rst_count", dut.count, 3'd0);
    reset = 0; inst_sram_req = 0; data_sram_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
    cyc();
    inst_sram_req = 1; inst_sram_addr = 32'hBFC0_0000; mem_addr_ok = 1;
    #1;
    chk("f_mem_req", mem_req, 1'b1);
    chk("f_mem_addr", mem_addr, 32'hBFC0_0000);
    chk("f_mem_wr", mem_wr, 1'b0);
    chk("f_mem_wstrb", mem_wstrb, 4'h0);
    chk("f_mem_wdata", mem_wdata, 32'h0);
    chk("f_inst_addr_ok", inst_sram_addr_ok, 1'b1);
    cyc();
    inst_sram_req = 0; mem_addr_ok = 0;
    cyc();
    mem_data_ok = 1; mem_rdata = 32'h1234_5678;
    #1;
    chk("f_inst_data_ok", inst_sram_data_ok, 1'b1);
    chk("f_inst_rdata", inst_sram_rdata, 32'h1234_5678);
    chk("f_data_data_ok", data_sram_data_ok, 1'b0);
    cyc();
    mem_data_ok = 0;
    chk("f_count", dut.count, 3'd0);
    inst_sram_req = 1; inst_sram_addr = 32'hBFC0_0004;
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h0000_1000; mem_addr_ok = 1;
    #1;
    chk("c_data_addr_ok", data_sram_addr_ok, 1'b1);
    chk("c_inst_addr_ok0", inst_sram_addr_ok, 1'b0);
    chk("c_mem_addr0", mem_addr, 32'h0000_1000);
    cyc();
    data_sram_req = 0;
    #1;
    chk("c_inst_addr_ok1", inst_sram_addr_ok, 1'b1);
    chk("c_mem_addr1", mem_addr, 32'hBFC0_0004);
    cyc();
    inst_sram_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hAAAA_0000;
    #1;
    chk("c_r1_data_ok", data_sram_data_ok, 1'b1);
    chk("c_r1_inst_ok", inst_sram_data_ok, 1'b0);
    chk("c_r1_rdata", data_sram_rdata, 32'hAAAA_0000);
    cyc();
    mem_rdata = 32'h5555_FFFF;
    #1;
    chk("c_r2_inst_ok", inst_sram_data_ok, 1'b1);
    chk("c_r2_data_ok", data_sram_data_ok, 1'b0);
    chk("c_r2_rdata", inst_sram_rdata, 32'h5555_FFFF);
    cyc();
    mem_data_ok = 0;
    inst_sram_req = 1; mem_addr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("full_fill_addr_ok", inst_sram_addr_ok, 1'b1);
      cyc();
    end
    chk("full_count4", dut.count, 3'd4);
    chk("full_blocked", mem_req, 1'b0);
    mem_data_ok = 1;
    #1;
    chk("full_pop_blocked", mem_req, 1'b0);
    chk("full_pop_inst_ok", inst_sram_data_ok, 1'b1);
    cyc();
    mem_data_ok = 0;
    #1;
    chk("full_5th_accept", inst_sram_addr_ok, 1'b1);
    cyc();
    chk("full_count_after", dut.count, 3'd4);
    inst_sram_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("full_drain", inst_sram_data_ok, 1'b1);
      cyc();
    end
    mem_data_ok = 0;
    chk("full_empty", dut.count, 3'd0);
    inst_sram_req = 1; data_sram_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("stv_data_grant", data_sram_addr_ok, (i % 5) != 4);
      chk("stv_inst_grant", inst_sram_addr_ok, (i % 5) == 4);
      if (i > 0) chk("stv_inst_resp", inst_sram_data_ok, (i % 5) == 0);
      cyc();
    end
    inst_sram_req = 0; data_sram_req = 0; mem_addr_ok = 0;
    #1;
    chk("stv_last_resp", inst_sram_data_ok, 1'b1);
    cyc();
    mem_data_ok = 0;
    data_sram_req = 1; data_sram_wr = 1; mem_addr_ok = 1;
    cyc(); cyc(); cyc();
    chk("rs_count3", dut.count, 3'd3);
    data_sram_req = 0; mem_addr_ok = 0; reset = 1; mem_data_ok = 1;
    #1;
    chk("rs_no_data_ok", {inst_sram_data_ok, data_sram_data_ok}, 2'b00);
    cyc();
    reset = 0; mem_data_ok = 0;
    chk("rs_count0", dut.count, 3'd0);
    inst_sram_req = 1; mem_addr_ok = 1;
    cyc();
    inst_sram_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h0BAD_F00D;
    #1;
    chk("rs_inst_ok", inst_sram_data_ok, 1'b1);
    chk("rs_data_ok", data_sram_data_ok, 1'b0);
    cyc();
    #1;
    chk("sp_no_data_ok", {inst_sram_data_ok, data_sram_data_ok}, 2'b00);
    cyc();
    mem_data_ok = 0;
    chk("sp_count", dut.count, 3'd0);
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h2000;
    data_sram_wstrb = 4'b0110; data_sram_wdata = 32'hDEAD_BEEF; mem_addr_ok = 1;
    #1;
    chk("sp_mem_wr", mem_wr, 1'b1);
    chk("sp_mem_wstrb", mem_wstrb, 4'b0110);
    chk("sp_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("sp_mem_addr", mem_addr, 32'h2000);
    cyc();
    data_sram_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    #1;
    chk("sp_store_ok", data_sram_data_ok, 1'b1);
    chk("sp_store_inst", inst_sram_data_ok, 1'b0);
    cyc();
    mem_data_ok = 0;
    chk("sp_final_count", dut.count, 3'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
